wta_first_spike: RTL and testbench
==================================

Name: wta_first_spike

Overview:
- Downstream consumer of a column of `neuron` accumulators; each neuron's spikes_out drives one bit of spikes_in.
- Runs one gamma window of GAMMA time steps, captures the earliest-firing neuron (1-winner-take-all) and its spike time, then presents the result through a valid/ready handshake.
- Drives a time-step count back to the upstream encoder and a lateral-inhibition mask to the column.

Parameters:
- NUM_NEURONS, 8, number of neurons in the column (spikes_in width).
- GAMMA, 16, time steps per gamma window; legal range 2..255.
- IBITS, $clog2(NUM_NEURONS), winner index width.
- TBITS, $clog2(GAMMA+1), time width; must be able to hold sentinel value GAMMA.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a window; honoured only in IDLE.
- spikes_in  in  NUM_NEURONS  level spike outputs of the neuron column.
- time_step  out  TBITS  current step within the window, 0..GAMMA-1; 0 outside RUN.
- busy  out  1  high in RUN and DONE.
- inhibit  out  NUM_NEURONS  lateral inhibition mask: all bits except the winner's, from the cycle after capture until leaving RUN.
- out_valid  out  1  result available (DONE state).
- out_ready  in  1  consumer accepts result.
- winner_idx  out  IBITS  index of the winning neuron.
- winner_time  out  TBITS  step at which the winner fired; GAMMA if none fired.
- no_spike  out  1  no neuron fired during the window.

Behaviour:
- Reset: async assertion forces IDLE from any state, including mid-window or DONE.
  - All outputs clear to 0: time_step, busy, inhibit, out_valid, winner_idx, winner_time, no_spike.
  - Internal captured flag clears; no partial result survives.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle.
  - time_step=0, captured=0, winner_idx=0, winner_time=GAMMA, no_spike=0.
- RUN:
  - time_step starts at 0 and increments by 1 each cycle.
  - spikes_in is sampled every RUN cycle, including step 0 and step GAMMA-1.
  - Capture: the first cycle in which captured=0 and spikes_in!=0:
    - winner_idx = lowest set bit index (tie-break: lowest index wins).
    - winner_time = time_step.
    - captured=1.
  - All later spikes in the window are ignored.
  - inhibit = ~onehot(winner_idx) from the cycle after capture while in RUN; 0 otherwise.
  - At time_step==GAMMA-1: -> DONE next cycle; time_step returns to 0.
  - Window length is fixed at GAMMA cycles with no early termination.
  - start is ignored in RUN.
- DONE:
  - out_valid=1; winner_idx, winner_time and no_spike held stable while out_valid=1 and out_ready=0.
  - no_spike = ~captured; if no_spike=1 then winner_idx=0 and winner_time=GAMMA.
  - out_valid & out_ready -> IDLE next cycle; out_valid drops that cycle.
  - start in DONE is ignored, including the handshake cycle; a new window needs start in IDLE.
- Latency:
  - start sampled at edge k -> RUN during cycles k+1..k+GAMMA.
  - out_valid high from cycle k+GAMMA+1.
  - Minimum start-to-start spacing is GAMMA+2 cycles with out_ready tied high.
- Width rules:
  - time_step and winner_time are unsigned TBITS values and never wrap within a window.
  - spikes_in bits at or above NUM_NEURONS do not exist; no padding.
- spikes_in is treated as already synchronous to clk; no internal synchronizer.

Test Plan:
- NUM_NEURONS=8, GAMMA=16; pulse start, spikes_in=0 until step 5, then 8'b0010_0000 held -> winner_idx=5, winner_time=5, no_spike=0, out_valid at cycle start+17; inhibit=8'b1101_1111 from step 6 through step 15.
- Simultaneous: spikes_in=8'b1001_0100 at step 3 -> winner_idx=2, winner_time=3; a later spike on bit 0 at step 4 does not change the result.
- No spike for a full window -> no_spike=1, winner_idx=0, winner_time=16, inhibit stays 0.
- Boundaries: first spike exactly at step 0 -> winner_time=0; separately, first spike only at step 15 -> winner_time=15 with no inhibit cycle inside RUN.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with spikes_in toggling -> outputs stable, out_valid held high; start pulses during RUN and DONE are ignored; out_ready=1 -> IDLE next cycle.
- Reset mid-window: assert rst_n=0 asynchronously at step 7 after a capture -> all outputs 0 immediately; after release and a new start with no spikes -> no_spike=1, showing no stale winner.

Source files
------------

// File: rtl/wta_first_spike.sv
// wta_first_spike: one gamma window of GAMMA steps over a neuron column,
// captures the earliest-firing neuron (lowest index on a tie) and its
// spike time, then holds the result on a valid/ready output until taken.
module wta_first_spike #(
  parameter int NUM_NEURONS = 8,
  parameter int GAMMA       = 16,
  parameter int IBITS       = $clog2(NUM_NEURONS),
  parameter int TBITS       = $clog2(GAMMA + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  output logic [TBITS-1:0]       time_step,
  output logic                   busy,
  output logic [NUM_NEURONS-1:0] inhibit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IBITS-1:0]       winner_idx,
  output logic [TBITS-1:0]       winner_time,
  output logic                   no_spike
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [TBITS-1:0] LAST_STEP = TBITS'(GAMMA - 1);
  localparam logic [TBITS-1:0] NO_TIME   = TBITS'(GAMMA);

  state_t           state, state_nxt;
  logic             captured;
  logic [IBITS-1:0] first_idx;
  logic             last_step;

  assign last_step = (time_step == LAST_STEP);

  // Lowest set bit of spikes_in; scanning downward lets the lowest index win.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--)
      if (spikes_in[i]) first_idx = IBITS'(i);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: fixed-length window, no early exit; start only counts in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Step counter and first-spike capture. IDLE preloads the "no winner"
  // result so a silent window needs no extra fix-up on the way to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_step   <= '0;
      captured    <= 1'b0;
      winner_idx  <= '0;
      winner_time <= '0;
    end else begin
      case (state)
        IDLE: begin
          time_step   <= '0;
          captured    <= 1'b0;
          winner_idx  <= '0;
          winner_time <= NO_TIME;
        end
        RUN: begin
          time_step <= last_step ? '0 : time_step + TBITS'(1);
          if (!captured && |spikes_in) begin
            captured    <= 1'b1;
            winner_idx  <= first_idx;
            winner_time <= time_step;
          end
        end
        default: ;  // DONE holds the result stable under backpressure
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign no_spike  = out_valid & ~captured;

  // Lateral inhibition: every neuron except the winner, only while running.
  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_inh
    assign inhibit[g] = (state == RUN) && captured && (winner_idx != IBITS'(g));
  end

endmodule

// File: tb/tb_wta_first_spike.sv
// Bench for wta_first_spike: table of windows with expected results pushed
// to a scoreboard at start and popped when out_valid appears, plus
// hand-written reset-mid-window sequence.
module tb_wta_first_spike;

  localparam int N  = 8;
  localparam int G  = 16;
  localparam int IB = 3;
  localparam int TB = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  spikes_in = '0;
  logic [TB-1:0] time_step;
  logic          busy;
  logic [N-1:0]  inhibit;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IB-1:0] winner_idx;
  logic [TB-1:0] winner_time;
  logic          no_spike;

  wta_first_spike #(.NUM_NEURONS(N), .GAMMA(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spikes_in(spikes_in),
    .time_step(time_step), .busy(busy), .inhibit(inhibit),
    .out_valid(out_valid), .out_ready(out_ready), .winner_idx(winner_idx),
    .winner_time(winner_time), .no_spike(no_spike)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           fs;     // first step with pattern pat (>= G: never)
    logic [N-1:0] pat;
    int           ls;     // later step adding lpat
    logic [N-1:0] lpat;
    int           hold;   // DONE cycles with out_ready low (noise + start pulses)
    int           eidx;
    int           etime;
    int           enone;
  } vec_t;

  typedef struct {
    int idx;
    int tm;
    int none;
  } res_t;

  res_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full window: start, drive GAMMA steps, check per-step outputs,
  // then pop the scoreboard when the result appears.
  task automatic run_window(input vec_t v);
    res_t r;
    int wait_cnt;
    logic [N-1:0] exp_inh;
    logic [IB-1:0] sidx, hidx;
    logic [TB-1:0] stm;
    logic sns;
    r.idx = v.eidx; r.tm = v.etime; r.none = v.enone;
    sb.push_back(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < G; s++) begin
      spikes_in = (s >= v.fs ? v.pat : '0) | (s >= v.ls ? v.lpat : '0);
      // stray start in the middle of RUN must be ignored
      start = (v.hold > 0 && s == 8);
      exp_inh = (v.fs < G && s > v.fs) ? ~(N'(1) << v.eidx) : '0;
      chk("time_step", int'(time_step), s);
      chk("busy_run", int'(busy), 1);
      chk("valid_run", int'(out_valid), 0);
      chk("inhibit", int'(inhibit), int'(exp_inh));
      tick();
    end
    start = 1'b0;
    spikes_in = '0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 5) begin
      tick();
      wait_cnt++;
    end
    chk("valid_latency", wait_cnt, 0);
    chk("time_step_done", int'(time_step), 0);
    chk("inhibit_done", int'(inhibit), 0);
    r = sb.pop_front();
    sidx = winner_idx; stm = winner_time; sns = no_spike;
    chk("winner_idx", int'(winner_idx), r.idx);
    chk("winner_time", int'(winner_time), r.tm);
    chk("no_spike", int'(no_spike), r.none);
    // backpressure: spikes toggle and start pulses, result must not move
    for (int h = 0; h < v.hold; h++) begin
      spikes_in = N'($urandom);
      start = h[0];
      tick();
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_idx", int'(winner_idx), int'(sidx));
      chk("bp_time", int'(winner_time), int'(stm));
      chk("bp_none", int'(no_spike), int'(sns));
    end
    out_ready = 1'b1;
    start = (v.hold > 0);  // start during the handshake cycle is ignored
    hidx = winner_idx;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    spikes_in = '0;
    chk("valid_after_hs", int'(out_valid), 0);
    chk("busy_after_hs", int'(busy), 0);
    chk("hs_idx_seen", int'(hidx), r.idx);
    tick();
    chk("idle_stays", int'(busy), 0);
  endtask

  vec_t tbl[6];
  vec_t nv;

  initial begin
    //         fs  pat            ls  lpat           hold idx tm  none
    tbl[0] = '{5,  8'b0010_0000,  99, 8'h00,         0,   5,  5,  0};
    tbl[1] = '{3,  8'b1001_0100,  4,  8'b0000_0001,  10,  2,  3,  0};
    tbl[2] = '{99, 8'h00,         99, 8'h00,         0,   0,  16, 1};
    tbl[3] = '{0,  8'b1000_0000,  99, 8'h00,         0,   7,  0,  0};
    tbl[4] = '{15, 8'b0000_1000,  99, 8'h00,         0,   3,  15, 0};
    tbl[5] = '{9,  8'b1111_1111,  12, 8'h01,         3,   0,  9,  0};

    // reset state
    #12;
    chk("rst_time_step", int'(time_step), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_inhibit", int'(inhibit), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(winner_idx), 0);
    chk("rst_time", int'(winner_time), 0);
    chk("rst_none", int'(no_spike), 0);
    rst_n = 1'b1;
    tick();
    tick();

    foreach (tbl[i]) run_window(tbl[i]);

    // reset mid-window after a capture at step 2
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 7; s++) begin
      spikes_in = (s >= 2) ? 8'b0100_0000 : '0;
      tick();
    end
    chk("mid_step", int'(time_step), 7);
    chk("mid_inhibit", int'(inhibit), int'(8'b1011_1111));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_time_step", int'(time_step), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_inhibit", int'(inhibit), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_idx", int'(winner_idx), 0);
    chk("arst_time", int'(winner_time), 0);
    chk("arst_none", int'(no_spike), 0);
    spikes_in = '0;
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    nv = '{99, 8'h00, 99, 8'h00, 0, 0, 16, 1};
    run_window(nv);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
